// File: rtl/pipe_chain.sv
// pipe_chain: parametrised chain of pipeline registers for the 16-bit core.
// Each stage holds a payload plus a valid bit and can be stalled, flushed or
// filled with a bubble. A RUN/DRAIN/HALTED state machine empties the pipe on
// request.
//
// Optional feature macro: PIPE_PERF_EN
//   defined     -> retired / stall_cycles performance counters are built.
//   not defined -> both counter outputs are tied to zero.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_valid     payload offered to stage 0
//   in_data      payload for stage 0
//   in_ready     stage 0 accepts this cycle (combinational)
//   stall_req    hold stages 0..stall_at
//   stall_at     oldest held stage (clamped to STAGES-1)
//   flush_req    clear stages 0..flush_at
//   flush_at     oldest flushed stage (clamped to STAGES-1)
//   halt_req     start draining (level)
//   stage_data   all stage payloads, stage k at [k*DATA_W +: DATA_W]
//   stage_valid  valid bit per stage
//   out_valid    valid of last stage
//   out_data     payload of last stage
//   occupancy    number of valid stages
//   halted       pipe has drained
//   retired      retired-payload counter (wraps)
//   stall_cycles stall cycle counter (wraps)
module pipe_chain #(
  parameter int                DATA_W = 16,
  parameter int                STAGES = 4,
  parameter logic [DATA_W-1:0] NOP    = '0,
  parameter int                IDX_W  = $clog2(STAGES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic                       stall_req,
  input  logic [IDX_W-1:0]           stall_at,
  input  logic                       flush_req,
  input  logic [IDX_W-1:0]           flush_at,
  input  logic                       halt_req,
  output logic [STAGES*DATA_W-1:0]   stage_data,
  output logic [STAGES-1:0]          stage_valid,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(STAGES+1)-1:0] occupancy,
  output logic                       halted,
  output logic [15:0]                retired,
  output logic [15:0]                stall_cycles
);

  localparam int          OCC_W = $clog2(STAGES+1);
  localparam int unsigned LAST  = STAGES - 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q [STAGES];
  logic [DATA_W-1:0]   data_d [STAGES];
  logic [STAGES-1:0]   valid_q, valid_d;
  int unsigned         f_idx, s_idx;
  logic                accept;

  // Out-of-range indices address the last stage.
  always_comb begin
    f_idx = 32'(flush_at);
    s_idx = 32'(stall_at);
    if (f_idx > LAST) f_idx = LAST;
    if (s_idx > LAST) s_idx = LAST;
  end

  assign in_ready  = (state_q == RUN) && !stall_req && !flush_req;
  assign accept    = in_valid && in_ready;
  assign occupancy = OCC_W'($countones(valid_q));

  // Per-stage next state; priority: flush, stall-hold, stall-bubble, advance.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k];
      data_d[k]  = data_q[k];
    end

    if (flush_req) begin
      valid_d[0] = 1'b0;
      data_d[0]  = NOP;
    end else if (!stall_req) begin
      valid_d[0] = accept;
      data_d[0]  = accept ? in_data : NOP;
    end

    for (int unsigned k = 1; k < STAGES; k++) begin
      if (flush_req && k <= f_idx) begin
        valid_d[k] = 1'b0;
        data_d[k]  = NOP;
      end else if (stall_req && k <= s_idx) begin
        valid_d[k] = valid_q[k];
        data_d[k]  = data_q[k];
      end else if (stall_req && k == s_idx + 1) begin
        valid_d[k] = 1'b0;
        data_d[k]  = NOP;
      end else begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) data_q[k] <= NOP;
    end else begin
      valid_q <= valid_d;
      for (int unsigned k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req) state_d = DRAIN;
      DRAIN:   if (occupancy == '0) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  assign halted = (state_q == HALTED);

  always_comb begin
    stage_data = '0;
    for (int unsigned k = 0; k < STAGES; k++)
      stage_data[k*DATA_W +: DATA_W] = data_q[k];
  end

  assign stage_valid = valid_q;
  assign out_valid   = valid_q[LAST];
  assign out_data    = data_q[LAST];

`ifdef PIPE_PERF_EN
  logic        retire_evt;
  logic [15:0] retired_q, stall_q;

  // Indices are clamped, so "covers the last stage" reduces to equality.
  assign retire_evt = valid_q[LAST] &&
                      !(flush_req && f_idx == LAST) &&
                      !(stall_req && s_idx == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire_evt) retired_q <= retired_q + 16'd1;
      if (stall_req)  stall_q   <= stall_q + 16'd1;
    end
  end

  assign retired      = retired_q;
  assign stall_cycles = stall_q;
`else
  assign retired      = 16'h0000;
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain (DATA_W=16, STAGES=4). A small behavioural
// model tracks stage contents; accepted payloads go into a scoreboard queue and
// are popped when they reach the last stage.
module tb_pipe_chain;

  localparam int DW = 16;
  localparam int NS = 4;
  localparam int IW = 2;
  localparam int OW = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic             in_ready;
  logic             stall_req = 1'b0;
  logic [IW-1:0]    stall_at = '0;
  logic             flush_req = 1'b0;
  logic [IW-1:0]    flush_at = '0;
  logic             halt_req = 1'b0;
  logic [NS*DW-1:0] stage_data;
  logic [NS-1:0]    stage_valid;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic [OW-1:0]    occupancy;
  logic             halted;
  logic [15:0]      retired;
  logic [15:0]      stall_cycles;

  pipe_chain #(
    .DATA_W(DW),
    .STAGES(NS),
    .NOP   (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .stall_req   (stall_req),
    .stall_at    (stall_at),
    .flush_req   (flush_req),
    .flush_at    (flush_at),
    .halt_req    (halt_req),
    .stage_data  (stage_data),
    .stage_valid (stage_valid),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .occupancy   (occupancy),
    .halted      (halted),
    .retired     (retired),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: 0=RUN 1=DRAIN 2=HALTED
  logic          m_v [NS];
  logic [DW-1:0] m_d [NS];
  int            m_state;
  logic [15:0]   m_ret, m_stall;
  logic [DW-1:0] sb [$];

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = '0;
    end
    m_state = 0;
    m_ret   = '0;
    m_stall = '0;
    sb.delete();
  endtask

  task automatic check_outputs();
    logic [NS*DW-1:0] exp_sd;
    logic [NS-1:0]    exp_sv;
    int               occ;
    occ = 0;
    for (int k = 0; k < NS; k++) begin
      exp_sd[k*DW +: DW] = m_d[k];
      exp_sv[k] = m_v[k];
      occ += int'(m_v[k]);
    end
    check("stage_valid", stage_valid, exp_sv);
    check("stage_data", stage_data, exp_sd);
    check("out_valid", out_valid, m_v[NS-1]);
    check("occupancy", occupancy, occ);
    check("halted", halted, m_state == 2);
`ifdef PIPE_PERF_EN
    check("retired", retired, m_ret);
    check("stall_cycles", stall_cycles, m_stall);
`else
    check("retired_tied", retired, 16'h0000);
    check("stall_cycles_tied", stall_cycles, 16'h0000);
`endif
  endtask

  // One clock: check in_ready, advance model with current inputs, edge, check.
  task automatic step();
    logic          nv [NS];
    logic [DW-1:0] nd [NS];
    int unsigned   fa, sa;
    bit            acc, pop_due, found, exp_rdy;
    int            occ;
    #1;
    exp_rdy = (m_state == 0) && !stall_req && !flush_req;
    check("in_ready", in_ready, exp_rdy);
    fa = flush_at;
    sa = stall_at;
    if (fa > NS - 1) fa = NS - 1;
    if (sa > NS - 1) sa = NS - 1;
    acc = exp_rdy && in_valid;
    pop_due = 0;
    for (int unsigned k = 0; k < NS; k++) begin
      if (flush_req && k <= fa) begin
        nv[k] = 1'b0; nd[k] = '0;
      end else if (stall_req && k <= sa) begin
        nv[k] = m_v[k]; nd[k] = m_d[k];
      end else if (stall_req && k == sa + 1) begin
        nv[k] = 1'b0; nd[k] = '0;
      end else if (k > 0) begin
        nv[k] = m_v[k-1]; nd[k] = m_d[k-1];
        if (k == NS - 1 && m_v[k-1]) pop_due = 1;
      end else begin
        nv[k] = acc; nd[k] = acc ? in_data : '0;
      end
    end
    // Payloads not yet at the last stage that vanish are dropped from the queue.
    for (int k = 0; k < NS - 1; k++) begin
      if (m_v[k]) begin
        found = 0;
        for (int j = 0; j < NS; j++)
          if (nv[j] && nd[j] == m_d[k]) found = 1;
        if (!found)
          for (int i = 0; i < sb.size(); i++)
            if (sb[i] == m_d[k]) begin
              sb.delete(i);
              break;
            end
      end
    end
    if (acc) sb.push_back(in_data);
    if (m_v[NS-1] && !(flush_req && fa == NS - 1) && !(stall_req && sa == NS - 1))
      m_ret = m_ret + 16'd1;
    if (stall_req) m_stall = m_stall + 16'd1;
    occ = 0;
    for (int k = 0; k < NS; k++) occ += int'(m_v[k]);
    if (m_state == 0 && halt_req) m_state = 1;
    else if (m_state == 1 && occ == 0) m_state = 2;
    @(posedge clk);
    #1;
    for (int k = 0; k < NS; k++) begin
      m_v[k] = nv[k];
      m_d[k] = nd[k];
    end
    if (pop_due) begin
      if (sb.size() > 0) check("out_data", out_data, sb.pop_front());
      else check("sb_empty", 64'(sb.size()), 64'd1);
    end
    check_outputs();
  endtask

  task automatic set_in(input logic v, input logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stall_req = 1'b0; flush_req = 1'b0; halt_req = 1'b0; in_valid = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit seen;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Fill and latency
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 16'h1001 + 16'(i));
      step();
    end
    check("fill_out_data", out_data, 16'h1001);
    check("fill_out_valid", out_valid, 1'b1);
    check("fill_occ", occupancy, 3'd4);
    for (int i = 4; i < 8; i++) begin
      set_in(1'b1, 16'h1001 + 16'(i));
      step();
    end

    // Load-use stall on stages 0..1
    set_in(1'b1, 16'h1009);
    stall_req = 1'b1; stall_at = 2'd1;
    step();
    stall_req = 1'b0;
    check("stall_shape", stage_valid, 4'b1011);
    for (int i = 9; i < 14; i++) begin
      set_in(1'b1, 16'h1000 + 16'(i));
      step();
    end

    // Flush 0..1 together with stall 0..2
    set_in(1'b1, 16'hbad0);
    flush_req = 1'b1; flush_at = 2'd1;
    stall_req = 1'b1; stall_at = 2'd2;
    step();
    flush_req = 1'b0; stall_req = 1'b0;
    check("flush_low", stage_valid[1:0], 2'b00);
    check("flush_held", stage_valid[2], 1'b1);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 16'h1100 + 16'(i));
      step();
    end

    // Drain from a full pipe
    check("pre_drain_occ", occupancy, 3'd4);
    set_in(1'b0, '0);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    set_in(1'b1, 16'hdead);
    for (int i = 0; i < 3; i++) step();
    check("drain_not_yet", halted, 1'b0);
    step();
    check("drain_halted", halted, 1'b1);
    step();
    check("halt_ignores_in", stage_valid, 4'b0000);

    // Async reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 16'h1200 + 16'(i));
      step();
    end
    set_in(1'b0, '0);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    step();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("areset_valid", stage_valid, 4'b0000);
    check("areset_halted", halted, 1'b0);
    check("areset_occ", occupancy, 3'd0);
    #1;
    rst = 1'b1;
    set_in(1'b1, 16'h2001);
    step();
    check("post_reset_accept", stage_valid[0], 1'b1);
    check("post_reset_data", stage_data[DW-1:0], 16'h2001);

`ifdef PIPE_PERF_EN
    // Retired counter wrap
    do_reset();
    seen = 0;
    for (int i = 0; i < 70000; i++) begin
      set_in(1'b1, 16'h3000 + 16'(i));
      step();
      if (m_ret != 16'h0000) seen = 1;
      if (seen && m_ret == 16'h0000) break;
    end
    check("wrap_seen", seen, 1'b1);
    check("retired_wrap", retired, 16'h0000);
`else
    seen = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
